// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory access stage: funct3 encodings,
// FSM state type and the default access timeout.
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int MEM_TIMEOUT = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mem_state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the memory stage: extracts and extends load data
// from the read word, and builds byte enables plus lane-replicated store data.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata_raw,
  output logic [31:0] rdata_fmt,
  output logic [31:0] wdata_rep,
  output logic [3:0]  be
);

  logic [7:0]  rd_byte;
  logic [15:0] rd_half;

  // Select the addressed byte and halfword lanes of the read word.
  always_comb begin
    rd_byte = rdata[7:0];
    case (addr_lo)
      2'd0: rd_byte = rdata[7:0];
      2'd1: rd_byte = rdata[15:8];
      2'd2: rd_byte = rdata[23:16];
      2'd3: rd_byte = rdata[31:24];
      default: rd_byte = rdata[7:0];
    endcase
    rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  // Sign/zero extension; any undefined size falls back to a full word.
  always_comb begin
    rdata_fmt = rdata;
    case (funct3)
      F3_LB:   rdata_fmt = {{24{rd_byte[7]}}, rd_byte};
      F3_LBU:  rdata_fmt = {24'h0, rd_byte};
      F3_LH:   rdata_fmt = {{16{rd_half[15]}}, rd_half};
      F3_LHU:  rdata_fmt = {16'h0, rd_half};
      default: rdata_fmt = rdata;
    endcase
  end

  // Store lane enables and replication; halfword ignores addr bit 0.
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_raw;
    case (funct3)
      F3_SB: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata_raw[7:0]}};
      end
      F3_SH: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_raw[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata_raw;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-memory access stage: converts an EX/MEM load/store into a req/ack
// transaction, stalls the pipeline until it completes, aborts after
// TIMEOUT_CYC unacknowledged cycles, and presents formatted load data.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses without touching memory.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = MEM_TIMEOUT
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  output logic [31:0] Memdata_o,
  output logic        stall_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [29:0]       addr_q;
  logic [1:0]        lo_q;
  logic              we_q;
  logic [2:0]        f3_q;
  logic [31:0]       wraw_q;
  logic [31:0]       memdata_q;
  logic              err_q;
  logic              mis_q;
  logic              access;
  logic              misalign_det;
  logic              timeout;
  logic [31:0]       rdata_fmt;

  assign access  = MemRead_i | MemWrite_i;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_det = ((funct3_i[1:0] == 2'b01) && ALUResult_i[0]) ||
                        ((funct3_i == F3_LW) && (ALUResult_i[1:0] != 2'b00));
`else
  assign misalign_det = 1'b0;
`endif

  // Lane logic runs off the captured copies so request fields stay stable.
  mem_lane_align u_align (
    .funct3    (f3_q),
    .addr_lo   (lo_q),
    .rdata     (mem_rdata_i),
    .wdata_raw (wraw_q),
    .rdata_fmt (rdata_fmt),
    .wdata_rep (mem_wdata_o),
    .be        (mem_be_o)
  );

  assign mem_addr_o = {addr_q, 2'b00};
  assign mem_we_o   = we_q;
  assign Memdata_o  = memdata_q;
  assign bus_err_o  = err_q;
  assign misalign_o = mis_q;

  // Next-state, stall and request decode.
  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    mem_req_o = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access) begin
          stall_o = 1'b1;
          state_d = misalign_det ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        stall_o   = 1'b1;
        mem_req_o = 1'b1;
        if (mem_ack_i || timeout) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (rst_i) stall_o = 1'b0;
  end

  // State, capture registers, wait counter and result/pulse flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      lo_q      <= '0;
      we_q      <= 1'b0;
      f3_q      <= '0;
      wraw_q    <= '0;
      memdata_q <= '0;
      err_q     <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (access) begin
            addr_q <= ALUResult_i[31:2];
            lo_q   <= ALUResult_i[1:0];
            we_q   <= MemWrite_i;
            f3_q   <= funct3_i;
            wraw_q <= WriteData_i;
            cnt_q  <= '0;
            err_q  <= 1'b0;
            mis_q  <= misalign_det;
            if (misalign_det) memdata_q <= '0;
          end
        end
        ST_BUSY: begin
          if (mem_ack_i) begin
            if (!we_q) memdata_q <= rdata_fmt;
          end else if (timeout) begin
            memdata_q <= '0;
            err_q     <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          err_q <= 1'b0;
          mis_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
